// File: rtl/snake_mover.sv
// Grid snake: a step timer advances the head one cell in the current direction and shifts the body behind it.
// The snake grows on food, and game_over latches on a wall or self collision and freezes all state until reset.
module snake_mover #(
  parameter int STEP_CYCLES = 2500000,
  parameter int MAX_LEN     = 16,
  parameter int CELL        = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] dir_in,
  input  logic       dir_valid,
  input  logic [9:0] foodX,
  input  logic [8:0] foodY,
  input  logic [3:0] seg_sel,
  output logic [9:0] snakeX,
  output logic [8:0] snakeY,
  output logic [9:0] segX,
  output logic [8:0] segY,
  output logic [4:0] length,
  output logic       ate,
  output logic       game_over
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] TICK_COUNT = CNT_W'(STEP_CYCLES - 1);

  localparam logic [1:0] DIR_RIGHT = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  logic [CNT_W-1:0]   cnt_reg;
  logic [1:0]         cur_dir_reg;
  logic [1:0]         pend_dir_reg;
  logic [1:0]         dir_next;
  logic [9:0]         seg_x_reg [MAX_LEN];
  logic [8:0]         seg_y_reg [MAX_LEN];
  logic [4:0]         length_reg;
  logic               moved_reg;
  logic               ate_reg;
  logic               game_over_reg;
  logic               tick;
  logic               in_range;
  logic               shift_en;
  logic               food_hit;
  logic               body_hit;
  logic [11:0]        head_x_next;
  logic [10:0]        head_y_next;
  logic [MAX_LEN-1:0] hit_vec;

  assign tick = (cnt_reg == TICK_COUNT);

  // Directions pair up as 00/01 and 10/11, so the reverse of a direction differs only in bit 0.
  assign dir_next = (pend_dir_reg == (cur_dir_reg ^ 2'b01)) ? cur_dir_reg : pend_dir_reg;

  // Computed in widened arithmetic so a step past zero shows up as a large, out-of-range value.
  always_comb begin
    head_x_next = {2'b00, seg_x_reg[0]};
    head_y_next = {2'b00, seg_y_reg[0]};
    case (dir_next)
      DIR_RIGHT: head_x_next = {2'b00, seg_x_reg[0]} + 12'(CELL);
      DIR_LEFT:  head_x_next = {2'b00, seg_x_reg[0]} - 12'(CELL);
      DIR_UP:    head_y_next = {2'b00, seg_y_reg[0]} - 11'(CELL);
      default:   head_y_next = {2'b00, seg_y_reg[0]} + 11'(CELL);
    endcase
  end

  assign in_range = (head_x_next >= 12'd10) && (head_x_next <= 12'd630) &&
                    (head_y_next >= 11'd10) && (head_y_next <= 11'd470);
  assign shift_en = tick && in_range && !game_over_reg;

  assign food_hit = (seg_x_reg[0] == foodX) && (seg_y_reg[0] == foodY);

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_hit
      if (gi == 0) begin : g_head
        assign hit_vec[gi] = 1'b0;
      end else begin : g_body
        assign hit_vec[gi] = (5'(gi) < length_reg) &&
                             (seg_x_reg[gi] == seg_x_reg[0]) &&
                             (seg_y_reg[gi] == seg_y_reg[0]);
      end
    end
  endgenerate

  assign body_hit = |hit_vec;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_reg       <= '0;
      cur_dir_reg   <= DIR_RIGHT;
      pend_dir_reg  <= DIR_RIGHT;
      length_reg    <= 5'd3;
      moved_reg     <= 1'b0;
      ate_reg       <= 1'b0;
      game_over_reg <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_reg[i] <= 10'd0;
        seg_y_reg[i] <= 9'd0;
      end
      seg_x_reg[0] <= 10'd320;
      seg_y_reg[0] <= 9'd240;
      seg_x_reg[1] <= 10'd310;
      seg_y_reg[1] <= 9'd240;
      seg_x_reg[2] <= 10'd300;
      seg_y_reg[2] <= 9'd240;
    end else begin
      moved_reg <= shift_en;
      ate_reg   <= 1'b0;
      if (!game_over_reg) begin
        cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        if (dir_valid) begin
          pend_dir_reg <= dir_in;
        end
        if (tick) begin
          cur_dir_reg <= dir_next;
          if (in_range) begin
            seg_x_reg[0] <= head_x_next[9:0];
            seg_y_reg[0] <= head_y_next[8:0];
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_reg[i] <= seg_x_reg[i-1];
              seg_y_reg[i] <= seg_y_reg[i-1];
            end
          end else begin
            game_over_reg <= 1'b1;
          end
        end
        // Food and self-collision are judged on the head position settled by the previous move.
        if (moved_reg) begin
          if (food_hit) begin
            ate_reg <= 1'b1;
            if (length_reg < 5'(MAX_LEN)) begin
              length_reg <= length_reg + 5'd1;
            end
          end
          if (body_hit) begin
            game_over_reg <= 1'b1;
          end
        end
      end
    end
  end

  assign snakeX    = seg_x_reg[0];
  assign snakeY    = seg_y_reg[0];
  assign length    = length_reg;
  assign ate       = ate_reg;
  assign game_over = game_over_reg;

  assign segX = ({1'b0, seg_sel} < length_reg) ? seg_x_reg[seg_sel[IDX_W-1:0]] : 10'd0;
  assign segY = ({1'b0, seg_sel} < length_reg) ? seg_y_reg[seg_sel[IDX_W-1:0]] : 9'd0;

endmodule

// File: tb/tb_snake_mover.sv
// Bench for snake_mover: a queue-based model of the snake is checked against the DUT every cycle,
// alongside directed scenarios with literal expectations and a randomized phase.
module tb_snake_mover;

  localparam int S  = 4;
  localparam int ML = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dir_in = 2'b00;
  logic       dir_valid = 1'b0;
  logic [9:0] foodX = 10'd600;
  logic [8:0] foodY = 9'd400;
  logic [3:0] seg_sel = 4'd0;
  logic [9:0] snakeX;
  logic [8:0] snakeY;
  logic [9:0] segX;
  logic [8:0] segY;
  logic [4:0] length;
  logic       ate;
  logic       game_over;

  int n_pass = 0;
  int n_total = 0;

  snake_mover #(.STEP_CYCLES(S), .MAX_LEN(ML), .CELL(10)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .dir_in   (dir_in),
    .dir_valid(dir_valid),
    .foodX    (foodX),
    .foodY    (foodY),
    .seg_sel  (seg_sel),
    .snakeX   (snakeX),
    .snakeY   (snakeY),
    .segX     (segX),
    .segY     (segY),
    .length   (length),
    .ate      (ate),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: the body is a queue of cell positions, head at the front.
  int dx[4]  = '{10, -10, 0, 0};
  int dy[4]  = '{0, 0, -10, 10};
  int opp[4] = '{1, 0, 3, 2};
  int m_x[$];
  int m_y[$];
  int m_cnt, m_cur, m_pend, m_len;
  bit m_ate, m_go, m_moved, m_valid = 0;

  task automatic m_init();
    m_x.delete();
    m_y.delete();
    m_x.push_back(320); m_y.push_back(240);
    m_x.push_back(310); m_y.push_back(240);
    m_x.push_back(300); m_y.push_back(240);
    while (m_x.size() < ML) begin
      m_x.push_back(0);
      m_y.push_back(0);
    end
    m_cnt = 0; m_cur = 0; m_pend = 0; m_len = 3;
    m_ate = 0; m_go = 0; m_moved = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_init();
      m_valid = 1;
    end else if (m_valid) begin
      bit was_moved;
      int nd, nx, ny, old_len;
      was_moved = m_moved;
      m_moved = 0;
      m_ate = 0;
      if (!m_go) begin
        old_len = m_len;
        if (was_moved) begin
          if (m_x[0] == int'(foodX) && m_y[0] == int'(foodY)) begin
            m_ate = 1;
            if (m_len < ML) m_len++;
          end
          for (int k = 1; k < old_len; k++)
            if (m_x[k] == m_x[0] && m_y[k] == m_y[0]) m_go = 1;
        end
        if (m_cnt == S - 1) begin
          m_cnt = 0;
          nd = (m_pend == opp[m_cur]) ? m_cur : m_pend;
          m_cur = nd;
          nx = m_x[0] + dx[nd];
          ny = m_y[0] + dy[nd];
          if (nx < 10 || nx > 630 || ny < 10 || ny > 470) begin
            m_go = 1;
          end else begin
            m_x.push_front(nx); m_y.push_front(ny);
            void'(m_x.pop_back()); void'(m_y.pop_back());
            m_moved = 1;
          end
        end else begin
          m_cnt++;
        end
        if (dir_valid) m_pend = int'(dir_in);
      end
    end
  end

  // Single compare process: all outputs against the model, every cycle after the first reset.
  always @(negedge clk) begin
    #1;
    if (m_valid) begin
      int sel;
      sel = int'(seg_sel);
      check("snakeX", int'(snakeX), m_x[0]);
      check("snakeY", int'(snakeY), m_y[0]);
      check("length", int'(length), m_len);
      check("ate", int'(ate), int'(m_ate));
      check("game_over", int'(game_over), int'(m_go));
      check("segX", int'(segX), (sel < m_len) ? m_x[sel] : 0);
      check("segY", int'(segY), (sel < m_len) ? m_y[sel] : 0);
    end
  end

  task automatic do_reset(input int fx, input int fy);
    @(negedge clk);
    reset = 1'b1;
    dir_valid = 1'b0;
    foodX = 10'(fx);
    foodY = 9'(fy);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_dir(input logic [1:0] d);
    dir_in = d;
    dir_valid = 1'b1;
    @(negedge clk);
    dir_valid = 1'b0;
  endtask

  task automatic check_seg(input string name, input int sel, input int ex, input int ey);
    seg_sel = 4'(sel);
    #1;
    check({name, "_x"}, int'(segX), ex);
    check({name, "_y"}, int'(segY), ey);
  endtask

  initial begin
    int k;
    // Reset values and first two steps with no input.
    do_reset(600, 400);
    check("rst_x", int'(snakeX), 320);
    check("rst_y", int'(snakeY), 240);
    check("rst_len", int'(length), 3);
    check("rst_ate", int'(ate), 0);
    check("rst_go", int'(game_over), 0);
    check_seg("rst_seg1", 1, 310, 240);
    check_seg("rst_seg2", 2, 300, 240);
    check_seg("rst_seg3", 3, 0, 0);
    repeat (4) @(negedge clk);
    check("step1_x", int'(snakeX), 330);
    check("step1_y", int'(snakeY), 240);
    repeat (4) @(negedge clk);
    check("step2_x", int'(snakeX), 340);
    check("step2_len", int'(length), 3);
    $display("scenario idle_move done");

    // Reverse request ignored, then turn up.
    do_reset(600, 400);
    pulse_dir(2'b01);
    repeat (3) @(negedge clk);
    check("rev_x", int'(snakeX), 330);
    check("rev_y", int'(snakeY), 240);
    pulse_dir(2'b10);
    repeat (3) @(negedge clk);
    check("up_x", int'(snakeX), 330);
    check("up_y", int'(snakeY), 230);
    $display("scenario direction done");

    // Eating on the first step.
    do_reset(330, 240);
    repeat (4) @(negedge clk);
    check("eat_pre", int'(ate), 0);
    @(negedge clk);
    check("eat_pulse", int'(ate), 1);
    check("eat_len", int'(length), 4);
    check_seg("eat_seg3", 3, 300, 240);
    @(negedge clk);
    check("eat_post", int'(ate), 0);
    $display("scenario eat done");

    // Right wall.
    do_reset(600, 400);
    repeat (31 * 4) @(negedge clk);
    check("wall_x", int'(snakeX), 630);
    check("wall_go0", int'(game_over), 0);
    repeat (4) @(negedge clk);
    check("wall_go1", int'(game_over), 1);
    check("wall_hold", int'(snakeX), 630);
    repeat (6) @(negedge clk);
    check("wall_hold2", int'(snakeX), 630);
    check("wall_ate", int'(ate), 0);
    $display("scenario wall done");

    // Grow to five, then curl back into the body.
    do_reset(330, 240);
    repeat (5) @(negedge clk);
    foodX = 10'd340;
    repeat (4) @(negedge clk);
    check("grow_len", int'(length), 5);
    foodX = 10'd600;
    foodY = 9'd400;
    pulse_dir(2'b11);
    repeat (2) @(negedge clk);
    pulse_dir(2'b01);
    repeat (3) @(negedge clk);
    pulse_dir(2'b10);
    repeat (3) @(negedge clk);
    check("curl_x", int'(snakeX), 330);
    check("curl_y", int'(snakeY), 240);
    check("curl_go0", int'(game_over), 0);
    @(negedge clk);
    check("curl_go1", int'(game_over), 1);
    do_reset(600, 400);
    check("rerst_go", int'(game_over), 0);
    check("rerst_len", int'(length), 3);
    check("rerst_x", int'(snakeX), 320);
    check_seg("rerst_seg2", 2, 300, 240);
    $display("scenario self_collision done");

    // Randomized phase against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      seg_sel = 4'($urandom_range(0, 15));
      dir_valid = ($urandom_range(0, 7) == 0);
      dir_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 3);
        foodX = 10'(m_x[0] + dx[k]);
        foodY = 9'(m_y[0] + dy[k]);
      end
      if ($urandom_range(0, 299) == 0 || (m_go && $urandom_range(0, 15) == 0)) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    dir_valid = 1'b0;
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/snake_mover.md
SNAKE_MOVER -- requirements
Module: snake_mover

Interface
REQ-001 Parameter STEP_CYCLES, default 2500000, clock cycles per movement step.
REQ-002 Parameter MAX_LEN, default 16, body segment capacity; power of two, at most 16.
REQ-003 Parameter CELL, default 10, pixels per grid step.
REQ-004 CLOCK_50  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 dir_in  input  2  requested direction: 00 right, 01 left, 10 up, 11 down.
REQ-007 dir_valid  input  1  qualifies dir_in for one cycle.
REQ-008 foodX  input  10  current food X pixel coordinate.
REQ-009 foodY  input  9  current food Y pixel coordinate.
REQ-010 seg_sel  input  4  body segment index for the renderer read port.
REQ-011 snakeX  output  10  head X coordinate, registered.
REQ-012 snakeY  output  9  head Y coordinate, registered.
REQ-013 segX  output  10  X of segment seg_sel, combinational read.
REQ-014 segY  output  9  Y of segment seg_sel, combinational read.
REQ-015 length  output  5  active segment count, head included.
REQ-016 ate  output  1  one-cycle pulse when the head lands on the food.
REQ-017 game_over  output  1  sticky collision flag.

Function
REQ-018 The step counter SHALL count 0..STEP_CYCLES-1 and wrap; the count STEP_CYCLES-1 is the tick cycle.
REQ-019 A dir_valid cycle SHALL latch dir_in into a pending-direction register; a later dir_valid SHALL overwrite it.
REQ-020 On a tick, pending direction SHALL become current direction unless it is the exact opposite of current direction, in which case it is discarded.
REQ-021 On a tick, the head SHALL move CELL pixels in current direction: right +X, left -X, up -Y, down +Y.
REQ-022 On a tick, segment[i] SHALL take segment[i-1] for i = 1..MAX_LEN-1 in the same edge that updates the head (segment[0] = head).
REQ-023 Legal head range: X 10..630, Y 10..470; a move whose next head falls outside this range SHALL NOT update head or body and SHALL set game_over.
REQ-024 In the cycle after a move, ate SHALL assert for exactly one cycle if snakeX==foodX and snakeY==foodY.
REQ-025 On that same edge, length SHALL increment, saturating at MAX_LEN.
REQ-026 In the cycle after a move, if the head equals any segment[1..length-1], game_over SHALL set.
REQ-027 While game_over is 1, the counter, head, body, length and ate SHALL hold; ate SHALL stay 0.
REQ-028 game_over SHALL clear only on reset.
REQ-029 dir_valid coinciding with a tick SHALL affect only the following tick.
REQ-030 When seg_sel >= length, segX and segY SHALL read 0.
REQ-031 Coordinates SHALL be unsigned; the range check SHALL be evaluated before the add/subtract is committed, so no wrap-around reaches the outputs.

Reset
REQ-032 On reset: counter 0, current and pending direction 00, head (320,240), segment1 (310,240), segment2 (300,240), remaining segments (0,0), length 3, ate 0, game_over 0.
REQ-033 Reset asserted mid-step SHALL discard the pending direction and restart the step count from 0.

Verification
REQ-034 Reset, STEP_CYCLES=4, food (600,400), no input -> head (330,240) after the first tick, (340,240) after the second; length 3.
REQ-035 dir_valid with 01 while moving right -> ignored, next head (330,240); then 10 -> next head (330,230).
REQ-036 Food at (330,240) -> ate high exactly one cycle after the first tick, length 4, segment3 = (300,240).
REQ-037 Drive right from reset until X=630, then one more tick -> game_over=1, head holds (630,240), ate stays 0.
REQ-038 Grow to length 5, then issue down, left, up on consecutive ticks -> head re-enters its own body and game_over sets; reset -> all REQ-032 values restored.
